// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared state encoding and default LFSR constants
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    localparam int DEF_WIDTH      = 9;
    localparam int DEF_TAP_HI     = 8;
    localparam int DEF_TAP_LO     = 4;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_LOSS_COUNT = 3;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational LFSR next-state, shared by checker and generator
module lfsr_step
    import lfsr_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TAP_HI = DEF_TAP_HI,
    parameter int TAP_LO = DEF_TAP_LO
) (
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = {w[WIDTH-2:0], w[TAP_HI] ^ w[TAP_LO]};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - LFSR sequence checker with hunt/verify/lock tracking
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TAP_HI     = DEF_TAP_HI,
    parameter int TAP_LO     = DEF_TAP_LO,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int LOSS_COUNT = DEF_LOSS_COUNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    input  logic             clear_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    chk_state_e         state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               stuck_q, stuck_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic [WIDTH-1:0]   prev_next;
    logic [RUN_W-1:0]   run_inc;
    logic [MISS_W-1:0]  miss_inc;
    logic               word_zero;
    logic               word_match;

    lfsr_step #(
        .WIDTH  (WIDTH),
        .TAP_HI (TAP_HI),
        .TAP_LO (TAP_LO)
    ) u_step (
        .w   (prev_q),
        .nxt (prev_next)
    );

    assign run_inc    = run_q + 1'b1;
    assign miss_inc   = miss_q + 1'b1;
    assign word_zero  = (in_word == '0);
    assign word_match = (in_word == prev_next);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        stuck_d     = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (word_zero) begin
                        stuck_d = 1'b1;
                    end else begin
                        prev_d  = in_word;
                        run_d   = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        prev_d = in_word;
                        run_d  = run_inc;
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else if (word_zero) begin
                        stuck_d = 1'b1;
                        state_d = HUNT;
                    end else begin
                        prev_d = in_word;
                        run_d  = '0;
                    end
                end
                LOCKED: begin
                    if (word_match) begin
                        prev_d = in_word;
                        miss_d = '0;
                    end else begin
                        // Flywheel: keep predicting from our own sequence instead of reseeding.
                        prev_d      = prev_next;
                        err_pulse_d = 1'b1;
                        stuck_d     = word_zero;
                        miss_d      = miss_inc;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (miss_inc == MISS_W'(LOSS_COUNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                            run_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (clear_count) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            stuck_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            stuck_q     <= stuck_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign stuck     = stuck_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

    logic        CLK;
    logic        reset;
    logic        in_valid;
    logic [8:0]  in_word;
    logic        clear_count;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        stuck;
    logic        s_locked;
    logic        s_err_pulse;
    logic [2:0]  s_err_count;
    logic        s_stuck;

    int total = 0;
    int bad   = 0;

    lfsr_checker dut (
        .CLK         (CLK),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .clear_count (clear_count),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .stuck       (stuck)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    lfsr_checker #(.CNT_W(3)) dut_small (
        .CLK         (CLK),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .clear_count (clear_count),
        .locked      (s_locked),
        .err_pulse   (s_err_pulse),
        .err_count   (s_err_count),
        .stuck       (s_stuck)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic [8:0] w);
        in_valid = 1'b1;
        in_word  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic lock_seq();
        feed(9'h014);
        feed(9'h029);
        feed(9'h052);
        feed(9'h0A5);
        feed(9'h14A);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_word     = '0;
        clear_count = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_stuck", stuck, 0);
        check("rst_err_count", err_count, 0);

        // Basic lock: 0x014 seeds, four matches lock on 0x14A
        feed(9'h014);
        feed(9'h029);
        feed(9'h052);
        feed(9'h0A5);
        check("lock_not_early", locked, 0);
        feed(9'h14A);
        check("lock_after_14a", locked, 1);
        check("lock_err_count", err_count, 0);

        // Zero word while locked: error + stuck, flywheel predicts 0x095 then 0x12B
        feed(9'h000);
        check("zero_err_pulse", err_pulse, 1);
        check("zero_stuck", stuck, 1);
        check("zero_err_count", err_count, 1);
        check("zero_still_locked", locked, 1);
        feed(9'h12B);
        check("match_err_pulse_clr", err_pulse, 0);
        check("match_stuck_clr", stuck, 0);
        check("match_locked", locked, 1);
        // miss was cleared by 0x12B, so two more errors must not drop lock
        feed(9'h1FF);
        feed(9'h1FF);
        check("miss_cleared_locked", locked, 1);
        check("miss_cleared_count", err_count, 3);

        // Three consecutive wrong words drop lock
        do_reset();
        lock_seq();
        feed(9'h1FF);
        check("loss1_count", err_count, 1);
        check("loss1_locked", locked, 1);
        feed(9'h1FF);
        check("loss2_locked", locked, 1);
        feed(9'h1FF);
        check("loss3_count", err_count, 3);
        check("loss3_locked", locked, 0);
        check("loss3_err_pulse", err_pulse, 1);
        feed(9'h000);
        check("hunt_stuck", stuck, 1);
        check("hunt_no_err", err_pulse, 0);
        feed(9'h014);
        feed(9'h029);
        feed(9'h052);
        feed(9'h0A5);
        check("hunt_relock_early", locked, 0);
        feed(9'h14A);
        check("hunt_relock", locked, 1);

        // Idle gap in the middle of verification
        do_reset();
        feed(9'h014);
        feed(9'h029);
        feed(9'h052);
        for (int i = 0; i < 5; i++) tick();
        check("gap_not_locked", locked, 0);
        feed(9'h0A5);
        feed(9'h14A);
        check("gap_locked", locked, 1);
        check("gap_no_err", err_pulse, 0);
        check("gap_err_count", err_count, 0);

        // Clear coinciding with a locked mismatch
        clear_count = 1'b1;
        feed(9'h1FF);
        clear_count = 1'b0;
        check("clr_err_count", err_count, 0);
        check("clr_err_pulse", err_pulse, 1);

        // Saturation on the narrow counter
        do_reset();
        for (int r = 0; r < 2; r++) begin
            lock_seq();
            for (int e = 0; e < 3; e++) feed(9'h1FF);
        end
        check("sat_small_6", s_err_count, 6);
        lock_seq();
        for (int e = 0; e < 3; e++) feed(9'h1FF);
        check("sat_small_7", s_err_count, 7);
        check("sat_main_9", err_count, 9);
        lock_seq();
        feed(9'h1FF);
        check("sat_small_hold", s_err_count, 7);
        check("sat_small_pulse", s_err_pulse, 1);
        check("sat_main_10", err_count, 10);
        check("sat_locked", locked, 1);

        // Reset mid-LOCKED overrides a simultaneous mismatch
        in_valid = 1'b1;
        in_word  = 9'h1FF;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_locked", locked, 0);
        check("rst_mid_err_pulse", err_pulse, 0);
        check("rst_mid_stuck", stuck, 0);
        check("rst_mid_err_count", err_count, 0);

        // First word after reset reseeds from a different point in the sequence
        feed(9'h0A5);
        feed(9'h14A);
        feed(9'h095);
        feed(9'h12B);
        check("reseed_early", locked, 0);
        feed(9'h057);
        check("reseed_locked", locked, 1);
        check("reseed_err_count", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
